// File: rtl/mig_app_pkg.sv
// Shared types and defaults for the MIG app-interface responder.
package mig_app_pkg;

  localparam int unsigned ADDRESS_SIZE = 28;
  localparam int unsigned CHUNK_PART   = 128;

  // Widest chunk index carried in a command entry; narrower memories zero-extend.
  localparam int unsigned MIG_INDEX_W = 24;

  localparam logic [2:0] MIG_CMD_WRITE = 3'b000;
  localparam logic [2:0] MIG_CMD_READ  = 3'b001;

  typedef struct packed {
    logic [2:0]             cmd;
    logic [MIG_INDEX_W-1:0] index;
  } mig_cmd_t;

  function automatic logic mig_cmd_known(input logic [2:0] cmd);
    return (cmd == MIG_CMD_WRITE) || (cmd == MIG_CMD_READ);
  endfunction

endpackage

// File: rtl/mig_sync_fifo.sv
// Show-ahead synchronous FIFO; fullness comes from registered occupancy only.
module mig_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == (PtrW+1)'(Depth));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      end
      if (do_push && !do_pop) begin
        cnt_q <= cnt_q + (PtrW+1)'(1);
      end else if (!do_push && do_pop) begin
        cnt_q <= cnt_q - (PtrW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/mig_app_responder.sv
// Block-RAM stand-in for the MIG DDR3 app interface with fixed read latency.
// Define MIG_RESPONDER_RANDOM_STALL_EN to add LFSR-driven ready backpressure.
module mig_app_responder #(
  parameter int unsigned ADDRESS_SIZE   = mig_app_pkg::ADDRESS_SIZE,
  parameter int unsigned CHUNK_PART     = mig_app_pkg::CHUNK_PART,
  parameter int unsigned MEM_DEPTH_LOG2 = 10,
  parameter int unsigned CALIB_CYCLES   = 64,
  parameter int unsigned READ_LATENCY   = 4,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDRESS_SIZE-1:0] app_addr,
  input  logic [2:0]              app_cmd,
  input  logic                    app_en,
  output logic                    app_rdy,
  input  logic [CHUNK_PART-1:0]   app_wdf_data,
  input  logic [CHUNK_PART/8-1:0] app_wdf_mask,
  input  logic                    app_wdf_wren,
  input  logic                    app_wdf_end,
  output logic                    app_wdf_rdy,
  output logic [CHUNK_PART-1:0]   app_rd_data,
  output logic                    app_rd_data_valid,
  output logic                    app_rd_data_end,
  output logic                    init_calib_complete,
  output logic                    protocol_error
);
  import mig_app_pkg::*;

  localparam int unsigned IdxW     = MEM_DEPTH_LOG2;
  localparam int unsigned MemDepth = 2 ** MEM_DEPTH_LOG2;
  localparam int unsigned MaskW    = CHUNK_PART / 8;
  localparam int unsigned WdfW     = CHUNK_PART + MaskW;
  localparam int unsigned CalW     = $clog2(CALIB_CYCLES + 1);

  mig_cmd_t         cmd_in, cmd_head;
  logic             cmd_push, cmd_pop, cmd_full, cmd_empty;
  logic [WdfW-1:0]  wdf_in, wdf_head;
  logic             wdf_push, wdf_pop, wdf_full, wdf_empty;
  logic [IdxW-1:0]  head_idx;
  logic             exec_rd, exec_wr;
  logic             stall_cmd, stall_wdf;
  logic             calib_q;
  logic [CalW-1:0]  calib_cnt_q;
  logic             error_q, error_d;
  logic             unused_bits;

  logic [CHUNK_PART-1:0]   mem_q [MemDepth];
  logic [CHUNK_PART-1:0]   ram_rd_q;
  logic                    ram_vld_q;
  logic [CHUNK_PART-1:0]   pipe_data_q [READ_LATENCY];
  logic [READ_LATENCY-1:0] pipe_vld_q;

`ifdef MIG_RESPONDER_RANDOM_STALL_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end
  end

  assign stall_cmd = lfsr_q[0];
  assign stall_wdf = lfsr_q[1];
`else
  assign stall_cmd = 1'b0;
  assign stall_wdf = 1'b0;
`endif

  always_comb begin
    app_rdy     = calib_q && !cmd_full && !stall_cmd;
    app_wdf_rdy = calib_q && !wdf_full && !stall_wdf;

    cmd_in       = '0;
    cmd_in.cmd   = app_cmd;
    cmd_in.index = MIG_INDEX_W'(app_addr[MEM_DEPTH_LOG2+3:4]);
    // Unknown commands are dropped here and only flagged.
    cmd_push     = app_en && app_rdy && mig_cmd_known(app_cmd);

    wdf_in   = {app_wdf_mask, app_wdf_data};
    wdf_push = app_wdf_wren && app_wdf_rdy;

    head_idx = cmd_head.index[IdxW-1:0];
    exec_rd  = !cmd_empty && (cmd_head.cmd == MIG_CMD_READ);
    exec_wr  = !cmd_empty && (cmd_head.cmd == MIG_CMD_WRITE) && !wdf_empty;
    cmd_pop  = exec_rd || exec_wr;
    wdf_pop  = exec_wr;

    error_d = error_q
            || (app_en && app_rdy && !mig_cmd_known(app_cmd))
            || (app_wdf_wren != app_wdf_end)
            || ((app_en || app_wdf_wren) && !calib_q);
  end

  assign unused_bits = ^{app_addr[3:0], app_addr[ADDRESS_SIZE-1:MEM_DEPTH_LOG2+4],
                         cmd_head.index[MIG_INDEX_W-1:IdxW]};

  mig_sync_fifo #(
    .Width ($bits(mig_cmd_t)),
    .Depth (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_push),
    .wdata (cmd_in),
    .pop   (cmd_pop),
    .rdata (cmd_head),
    .full  (cmd_full),
    .empty (cmd_empty)
  );

  mig_sync_fifo #(
    .Width (WdfW),
    .Depth (FIFO_DEPTH)
  ) u_wdf_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wdf_push),
    .wdata (wdf_in),
    .pop   (wdf_pop),
    .rdata (wdf_head),
    .full  (wdf_full),
    .empty (wdf_empty)
  );

  // RAM content survives reset; FPGA block RAM powers up cleared.
  always_ff @(posedge clk) begin
    if (exec_wr) begin
      for (int unsigned b = 0; b < MaskW; b++) begin
        if (!wdf_head[CHUNK_PART + b]) begin
          mem_q[head_idx][8*b +: 8] <= wdf_head[8*b +: 8];
        end
      end
    end
  end

  // RAM output register plus READ_LATENCY stages: valid READ_LATENCY+1 edges after execute.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_vld_q  <= 1'b0;
      ram_rd_q   <= '0;
      pipe_vld_q <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        pipe_data_q[i] <= '0;
      end
    end else begin
      ram_vld_q <= exec_rd;
      if (exec_rd) begin
        ram_rd_q <= mem_q[head_idx];
      end
      pipe_vld_q[0]  <= ram_vld_q;
      pipe_data_q[0] <= ram_rd_q;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_data_q[i] <= pipe_data_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      calib_q     <= 1'b0;
      calib_cnt_q <= '0;
      error_q     <= 1'b0;
    end else begin
      error_q <= error_d;
      if (!calib_q) begin
        if (calib_cnt_q == CalW'(CALIB_CYCLES - 1)) begin
          calib_q <= 1'b1;
        end else begin
          calib_cnt_q <= calib_cnt_q + CalW'(1);
        end
      end
    end
  end

  assign app_rd_data         = pipe_data_q[READ_LATENCY-1];
  assign app_rd_data_valid   = pipe_vld_q[READ_LATENCY-1];
  assign app_rd_data_end     = pipe_vld_q[READ_LATENCY-1];
  assign init_calib_complete = calib_q;
  assign protocol_error      = error_q;

endmodule

// File: tb/tb_mig_app_responder.sv
// Scoreboard bench for mig_app_responder: reads queue expected beats, a monitor collects returns.
module tb_mig_app_responder;

  localparam int L = 4;

  typedef struct packed { logic [2:0] cmd; logic [27:0] addr; logic [127:0] exp; } op_t;
  typedef struct packed { logic [127:0] d; logic [15:0] m; } beat_t;
  typedef struct packed { logic [127:0] d; int edge_n; } exp_t;
  typedef struct packed { logic [127:0] d; logic e; int cyc; } rx_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [27:0]  app_addr = '0;
  logic [2:0]   app_cmd = '0;
  logic         app_en = 1'b0;
  logic         app_rdy;
  logic [127:0] app_wdf_data = '0;
  logic [15:0]  app_wdf_mask = '0;
  logic         app_wdf_wren = 1'b0;
  logic         app_wdf_end = 1'b0;
  logic         app_wdf_rdy;
  logic [127:0] app_rd_data;
  logic         app_rd_data_valid;
  logic         app_rd_data_end;
  logic         init_calib_complete;
  logic         protocol_error;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_beat_edge = 0;

  op_t          ops_q[$];
  beat_t        beats_q[$];
  exp_t         exp_q[$];
  rx_t          rx_q[$];
  logic [127:0] model [1024];
  rx_t          mon_r;

  mig_app_responder u_dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .app_addr            (app_addr),
    .app_cmd             (app_cmd),
    .app_en              (app_en),
    .app_rdy             (app_rdy),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_mask        (app_wdf_mask),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_rdy         (app_wdf_rdy),
    .app_rd_data         (app_rd_data),
    .app_rd_data_valid   (app_rd_data_valid),
    .app_rd_data_end     (app_rd_data_end),
    .init_calib_complete (init_calib_complete),
    .protocol_error      (protocol_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (app_rd_data_valid === 1'b1) begin
      mon_r.d   = app_rd_data;
      mon_r.e   = app_rd_data_end;
      mon_r.cyc = cyc;
      rx_q.push_back(mon_r);
    end
  end

  function automatic int idx_of(input logic [27:0] addr);
    return int'(addr[13:4]);
  endfunction

  task automatic q_write(input logic [27:0] addr, input logic [127:0] d, input logic [15:0] m);
    op_t op;
    beat_t bt;
    int idx;
    idx = idx_of(addr);
    for (int b = 0; b < 16; b++) begin
      if (!m[b]) model[idx][8*b +: 8] = d[8*b +: 8];
    end
    op.cmd = 3'b000; op.addr = addr; op.exp = '0;
    bt.d = d; bt.m = m;
    ops_q.push_back(op);
    beats_q.push_back(bt);
  endtask

  task automatic q_read(input logic [27:0] addr);
    op_t op;
    op.cmd = 3'b001; op.addr = addr; op.exp = model[idx_of(addr)];
    ops_q.push_back(op);
  endtask

  // Drives queued commands and beats independently; a beat waits beat_delay cycles.
  task automatic run(input int beat_delay, input int max_cyc, output bit ok);
    bit acc, wacc;
    int edge_n;
    exp_t e;
    op_t op;
    beat_t bt;
    for (int k = 0; k < max_cyc; k++) begin
      if (ops_q.size() == 0 && beats_q.size() == 0) break;
      @(negedge clk);
      app_en = (ops_q.size() != 0);
      if (app_en) begin
        app_cmd = ops_q[0].cmd;
        app_addr = ops_q[0].addr;
      end
      app_wdf_wren = (beats_q.size() != 0) && (k >= beat_delay);
      app_wdf_end = app_wdf_wren;
      if (app_wdf_wren) begin
        app_wdf_data = beats_q[0].d;
        app_wdf_mask = beats_q[0].m;
      end
      acc = app_en && app_rdy;
      wacc = app_wdf_wren && app_wdf_rdy;
      edge_n = cyc + 1;
      @(posedge clk);
      if (acc) begin
        op = ops_q.pop_front();
        if (op.cmd == 3'b001) begin
          e.d = op.exp;
          e.edge_n = edge_n;
          exp_q.push_back(e);
        end
      end
      if (wacc) begin
        last_beat_edge = edge_n;
        bt = beats_q.pop_front();
      end
    end
    ok = (ops_q.size() == 0) && (beats_q.size() == 0);
    @(negedge clk);
    app_en = 1'b0;
    app_wdf_wren = 1'b0;
    app_wdf_end = 1'b0;
  endtask

  task automatic wait_rx(input int n, output bit ok);
    for (int k = 0; k < 300 && rx_q.size() < n; k++) @(posedge clk);
    ok = (rx_q.size() >= n);
    repeat (2 * L + 2) @(posedge clk);
  endtask

  task automatic wait_calib(output bit ok);
    for (int k = 0; k < 200 && init_calib_complete !== 1'b1; k++) @(negedge clk);
    ok = (init_calib_complete === 1'b1);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data_end, init_calib_complete,
         protocol_error} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b want 000000", {app_rdy, app_wdf_rdy,
               app_rd_data_valid, app_rd_data_end, init_calib_complete, protocol_error});
    end
    checks++;
    if (app_rd_data !== 128'h0) begin
      failures++;
      $display("FAIL reset_rd_data: got %h want 0", app_rd_data);
    end
  endtask

  task automatic test_calib;
    int r0;
    rst_n = 1'b1;
    r0 = cyc;
    while (cyc != r0 + 9) @(negedge clk);
    app_en = 1'b1; app_cmd = 3'b001; app_addr = '0;
    @(negedge clk);
    app_en = 1'b0;
    checks++;
    if (protocol_error !== 1'b1) begin
      failures++;
      $display("FAIL early_en_error: got %b want 1", protocol_error);
    end
    while (cyc != r0 + 63) @(negedge clk);
    checks++;
    if ({init_calib_complete, app_rdy} !== 2'b00) begin
      failures++;
      $display("FAIL calib_63: got %b want 00", {init_calib_complete, app_rdy});
    end
    @(negedge clk);
    checks++;
    if ({init_calib_complete, app_rdy, app_wdf_rdy} !== 3'b111) begin
      failures++;
      $display("FAIL calib_64: got %b want 111", {init_calib_complete, app_rdy, app_wdf_rdy});
    end
  endtask

  task automatic test_reset_clears_error;
    bit ok;
    @(negedge clk); rst_n = 1'b0;
    repeat (3) @(negedge clk); rst_n = 1'b1;
    wait_calib(ok);
    checks++;
    if (!ok || protocol_error !== 1'b0) begin
      failures++;
      $display("FAIL reset_clears_error: got calib=%b err=%b want 1 0", ok, protocol_error);
    end
  endtask

  task automatic test_write_read;
    bit ok;
    exp_t e;
    rx_t r;
    q_write(28'h40, {4{32'hDEADBEEF}}, 16'h0);
    run(0, 50, ok);
    q_read(28'h40);
    run(0, 50, ok);
    wait_rx(1, ok);
    checks++;
    if (!ok || rx_q.size() != 1) begin
      failures++;
      $display("FAIL wr_rd_count: got %0d beats want 1", rx_q.size());
    end else begin
      r = rx_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (r.d !== e.d || r.e !== 1'b1) begin
        failures++;
        $display("FAIL wr_rd_data: got %h end=%b want %h end=1", r.d, r.e, e.d);
      end
      checks++;
      if (r.cyc - e.edge_n != L + 1) begin
        failures++;
        $display("FAIL wr_rd_latency: got %0d edges want %0d", r.cyc - e.edge_n, L + 1);
      end
    end
  endtask

  task automatic test_masked_late;
    bit ok;
    exp_t e;
    rx_t r;
    q_write(28'h80, 128'h0, 16'h0);
    run(0, 50, ok);
    q_write(28'h80, {{15{8'h5A}}, 8'hA5}, 16'hFFFE);
    q_read(28'h80);
    run(3, 50, ok);
    wait_rx(1, ok);
    checks++;
    if (!ok || rx_q.size() != 1) begin
      failures++;
      $display("FAIL masked_count: got %0d beats want 1", rx_q.size());
    end else begin
      r = rx_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (r.d !== e.d) begin
        failures++;
        $display("FAIL masked_data: got %h want %h", r.d, e.d);
      end
      checks++;
      if (r.cyc < last_beat_edge + L + 2) begin
        failures++;
        $display("FAIL masked_order: got valid at %0d want >= %0d", r.cyc, last_beat_edge + L + 2);
      end
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    exp_t e;
    rx_t r;
    for (int i = 0; i < 5; i++) begin
      q_write(28'h100 + 28'(i * 16), {32'hB0000000 + 32'(i), 32'h1234_0000 + 32'(i),
              32'hCAFE_F00D, 32'(i * 7)}, 16'h0);
    end
    run(1000, 12, ok);
    checks++;
    if (ops_q.size() != 1 || app_rdy !== 1'b0) begin
      failures++;
      $display("FAIL bp_full: got pending=%0d rdy=%b want 1 0", ops_q.size(), app_rdy);
    end
    run(0, 60, ok);
    repeat (6) @(negedge clk);
    checks++;
    if (!ok || app_rdy !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: got done=%b rdy=%b want 1 1", ok, app_rdy);
    end
    for (int i = 0; i < 5; i++) q_read(28'h100 + 28'(i * 16));
    run(0, 60, ok);
    wait_rx(5, ok);
    checks++;
    if (!ok || rx_q.size() != 5) begin
      failures++;
      $display("FAIL bp_count: got %0d beats want 5", rx_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        r = rx_q.pop_front();
        e = exp_q.pop_front();
        checks++;
        if (r.d !== e.d) begin
          failures++;
          $display("FAIL bp_data[%0d]: got %h want %h", i, r.d, e.d);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    exp_t e;
    rx_t r;
    int c0;
    for (int i = 0; i < 16; i++) begin
      q_write(28'h400 + 28'(i * 16), {4{$urandom()}}, 16'h0);
    end
    q_write(28'h0, {4{32'h0A11A5ED}}, 16'h0);
    run(0, 100, ok);
    for (int i = 0; i < 16; i++) q_read(28'h400 + 28'(i * 16));
    q_read(28'h4000);
    run(0, 100, ok);
    wait_rx(17, ok);
    checks++;
    if (!ok || rx_q.size() != 17) begin
      failures++;
      $display("FAIL stream_count: got %0d beats want 17", rx_q.size());
    end else begin
      c0 = rx_q[0].cyc;
      for (int i = 0; i < 17; i++) begin
        r = rx_q.pop_front();
        e = exp_q.pop_front();
        checks++;
        if (r.d !== e.d || r.cyc != c0 + i) begin
          failures++;
          $display("FAIL stream[%0d]: got %h at %0d want %h at %0d", i, r.d, r.cyc, e.d, c0 + i);
        end
      end
    end
  endtask

  task automatic test_bad_cmd;
    @(negedge clk);
    app_en = 1'b1; app_cmd = 3'b010; app_addr = 28'h40;
    @(negedge clk);
    app_en = 1'b0;
    checks++;
    if (protocol_error !== 1'b1) begin
      failures++;
      $display("FAIL bad_cmd_error: got %b want 1", protocol_error);
    end
    repeat (12) @(negedge clk);
    checks++;
    if (rx_q.size() != 0) begin
      failures++;
      $display("FAIL bad_cmd_dropped: got %0d beats want 0", rx_q.size());
    end
  endtask

  task automatic test_reset_midflight;
    bit ok;
    exp_t e;
    rx_t r;
    q_write(28'h50, {4{32'h5EED_1234}}, 16'h0);
    run(0, 50, ok);
    repeat (5) @(negedge clk);
    q_read(28'h40);
    q_read(28'h50);
    run(0, 20, ok);
    rst_n = 1'b0;
    exp_q.delete();
    repeat (4) @(negedge clk);
    checks++;
    if (rx_q.size() != 0 || app_rd_data_valid !== 1'b0 || protocol_error !== 1'b0) begin
      failures++;
      $display("FAIL midflight_reset: got beats=%0d valid=%b err=%b want 0 0 0",
               rx_q.size(), app_rd_data_valid, protocol_error);
    end
    rst_n = 1'b1;
    wait_calib(ok);
    repeat (10) @(negedge clk);
    checks++;
    if (!ok || rx_q.size() != 0) begin
      failures++;
      $display("FAIL midflight_recal: got calib=%b beats=%0d want 1 0", ok, rx_q.size());
    end
    q_read(28'h50);
    q_read(28'h40);
    run(0, 50, ok);
    wait_rx(2, ok);
    checks++;
    if (!ok || rx_q.size() != 2) begin
      failures++;
      $display("FAIL retained_count: got %0d beats want 2", rx_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        r = rx_q.pop_front();
        e = exp_q.pop_front();
        checks++;
        if (r.d !== e.d) begin
          failures++;
          $display("FAIL retained_data[%0d]: got %h want %h", i, r.d, e.d);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) model[i] = '0;
    test_reset();
    test_calib();
    test_reset_clears_error();
    test_write_read();
    test_masked_late();
    test_backpressure();
    test_back_to_back();
    test_bad_cmd();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
